// File: rtl/simon_engine.sv
// ---------------------------------------------------------------------------
// simon_engine
//
// Parametrised Simon game core. It plays back a growing random sequence on
// the channel LEDs and then checks the player's presses one at a time as they
// arrive. A wrong or ambiguous press ends the game. Completing MAX_LEN rounds
// wins the game.
//
// Parameters
//   NUM_CH        number of button/LED channels (2..8)
//   MAX_LEN       sequence length that wins the game (1..255)
//   TICK_DIV      clk cycles per timing tick (>=2)
//   ON_TICKS      ticks each playback step is lit (>=1)
//   OFF_TICKS     dark ticks after each step and between rounds (>=1)
//   TIMEOUT_TICKS input timeout in ticks, used only with SIMON_TIMEOUT_EN
//
// Optional feature macro
//   SIMON_TIMEOUT_EN  when defined, WAIT_IN gives up after TIMEOUT_TICKS
//                     ticks without a correct press and goes to LOSE.
//                     When undefined, WAIT_IN waits indefinitely.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   btn        in   debounced button levels, 1 = pressed
//   start      in   debounced start button level
//   led        out  channel LEDs, at most one bit set (all set in WIN)
//   score      out  rounds completed in the current or last game
//   phase      out  state code: 0 IDLE, 1 ADD, 2 SHOW_ON, 3 SHOW_OFF,
//                   4 WAIT_IN, 5 GAP, 6 LOSE, 7 WIN
//   game_over  out  high while in LOSE
//   win        out  high while in WIN
// ---------------------------------------------------------------------------
module simon_engine #(
    parameter int NUM_CH        = 4,
    parameter int MAX_LEN       = 32,
    parameter int TICK_DIV      = 50_000_000,
    parameter int ON_TICKS      = 1,
    parameter int OFF_TICKS     = 1,
    parameter int TIMEOUT_TICKS = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] btn,
    input  logic              start,
    output logic [NUM_CH-1:0] led,
    output logic [7:0]        score,
    output logic [2:0]        phase,
    output logic              game_over,
    output logic              win
);

    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PW        = $clog2(TICK_DIV);
    localparam int DUR_MAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int DUR_MAX   = (DUR_MAX_A > TIMEOUT_TICKS) ? DUR_MAX_A : TIMEOUT_TICKS;
    localparam int DW        = $clog2(DUR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADD      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_GAP      = 3'd5,
        S_LOSE     = 3'd6,
        S_WIN      = 3'd7
    } state_t;

    state_t            state_reg, state_next;
    logic [7:0]        score_reg, score_next;
    logic [7:0]        len_reg,   len_next;
    logic [7:0]        idx_reg,   idx_next;
    logic [DW-1:0]     dur_reg,   dur_next;
    logic [PW-1:0]     presc_reg;
    logic [15:0]       lfsr_reg;
    logic [NUM_CH-1:0] btn_q_reg;
    logic              start_q_reg;

    logic              tick;
    logic              lfsr_fb;
    logic [NUM_CH-1:0] press;
    logic              start_edge;
    logic              press_onehot;
    logic              btn_onehot;
    logic [NUM_CH-1:0] exp_onehot;

    // Sequence memory: written once per round in ADD, read at the index the
    // FSM will hold next cycle so the entry is ready when the state needs it.
    logic [CH_W-1:0]   seq_mem [MAX_LEN];
    logic [CH_W-1:0]   rd_data_reg;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [CH_W-1:0]   wr_data;
    logic [AW-1:0]     rd_addr;

    assign tick         = (presc_reg == PW'(TICK_DIV - 1));
    // Fibonacci taps 16/14/13/11 for a right-shifting register.
    assign lfsr_fb      = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];
    assign press        = btn & ~btn_q_reg;
    assign start_edge   = start & ~start_q_reg;
    assign press_onehot = (press != '0) && ((press & (press - NUM_CH'(1))) == '0);
    assign btn_onehot   = (btn != '0) && ((btn & (btn - NUM_CH'(1))) == '0);
    assign exp_onehot   = NUM_CH'(1) << rd_data_reg;

    assign wr_en   = (state_reg == S_ADD);
    assign wr_addr = score_reg[AW-1:0];
    assign wr_data = CH_W'(lfsr_reg % 16'(NUM_CH));
    assign rd_addr = idx_next[AW-1:0];

    // Write-first bypass covers round 1, where entry 0 is written in ADD in
    // the same cycle SHOW_ON needs it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            seq_mem[wr_addr] <= wr_data;
        end
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_reg <= wr_data;
        end else begin
            rd_data_reg <= seq_mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            score_reg   <= 8'd0;
            len_reg     <= 8'd0;
            idx_reg     <= 8'd0;
            dur_reg     <= '0;
            presc_reg   <= '0;
            lfsr_reg    <= 16'hACE1;
            btn_q_reg   <= '0;
            start_q_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            score_reg   <= score_next;
            len_reg     <= len_next;
            idx_reg     <= idx_next;
            dur_reg     <= dur_next;
            presc_reg   <= tick ? '0 : presc_reg + 1'b1;
            lfsr_reg    <= {lfsr_fb, lfsr_reg[15:1]};
            btn_q_reg   <= btn;
            start_q_reg <= start;
        end
    end

    always_comb begin
        state_next = state_reg;
        score_next = score_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        dur_next   = dur_reg;

        case (state_reg)
            S_IDLE, S_LOSE, S_WIN: begin
                if (start_edge) begin
                    score_next = 8'd0;
                    state_next = S_ADD;
                end
            end
            S_ADD: begin
                len_next   = score_reg + 8'd1;
                idx_next   = 8'd0;
                dur_next   = '0;
                state_next = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (tick) begin
                    if (dur_reg == DW'(ON_TICKS - 1)) begin
                        dur_next   = '0;
                        state_next = S_SHOW_OFF;
                    end else begin
                        dur_next = dur_reg + 1'b1;
                    end
                end
            end
            S_SHOW_OFF: begin
                if (tick) begin
                    if (dur_reg == DW'(OFF_TICKS - 1)) begin
                        dur_next = '0;
                        if ((idx_reg + 8'd1) < len_reg) begin
                            idx_next   = idx_reg + 8'd1;
                            state_next = S_SHOW_ON;
                        end else begin
                            idx_next   = 8'd0;
                            state_next = S_WAIT_IN;
                        end
                    end else begin
                        dur_next = dur_reg + 1'b1;
                    end
                end
            end
            S_WAIT_IN: begin
`ifdef SIMON_TIMEOUT_EN
                // Timeout count; a press in the same cycle overrides it below.
                if (tick) begin
                    dur_next = dur_reg + 1'b1;
                    if ((dur_reg + 1'b1) == DW'(TIMEOUT_TICKS)) begin
                        state_next = S_LOSE;
                    end
                end
`else
                // No timeout: the player may take as long as they like.
`endif
                if (press != '0) begin
                    if (press_onehot && (press == exp_onehot)) begin
                        dur_next   = '0;
                        state_next = S_WAIT_IN;
                        if (idx_reg == (len_reg - 8'd1)) begin
                            score_next = score_reg + 8'd1;
                            if ((score_reg + 8'd1) == 8'(MAX_LEN)) begin
                                state_next = S_WIN;
                            end else begin
                                state_next = S_GAP;
                            end
                        end else begin
                            idx_next = idx_reg + 8'd1;
                        end
                    end else begin
                        state_next = S_LOSE;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (dur_reg == DW'(OFF_TICKS - 1)) begin
                        dur_next   = '0;
                        state_next = S_ADD;
                    end else begin
                        dur_next = dur_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        led = '0;
        case (state_reg)
            S_SHOW_ON: led = exp_onehot;
            S_WAIT_IN: led = btn_onehot ? btn : '0;
            S_WIN:     led = '1;
            default:   led = '0;
        endcase
    end

    assign score     = score_reg;
    assign phase     = state_reg;
    assign game_over = (state_reg == S_LOSE);
    assign win       = (state_reg == S_WIN);

endmodule

// File: tb/tb_simon_engine.sv
// ---------------------------------------------------------------------------
// tb_simon_engine
//
// Directed bench for simon_engine with NUM_CH=4, TICK_DIV=4, ON/OFF_TICKS=1.
// Two instances share clock, reset and buttons: dut (MAX_LEN=32) covers the
// main game, losing, idle waiting/timeout and reset; dut_w (MAX_LEN=3) covers
// winning. The expected random channels come from an independent LFSR that
// runs from the same reset.
// ---------------------------------------------------------------------------
module tb_simon_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       start;
    logic       start_w;

    logic [3:0] led,   led_w;
    logic [7:0] score, score_w;
    logic [2:0] phase, phase_w;
    logic       game_over, game_over_w;
    logic       win,   win_w;

    always #5 clk = ~clk;

    simon_engine #(
        .NUM_CH(4), .MAX_LEN(32), .TICK_DIV(4),
        .ON_TICKS(1), .OFF_TICKS(1), .TIMEOUT_TICKS(5)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .start(start),
        .led(led), .score(score), .phase(phase),
        .game_over(game_over), .win(win)
    );

    simon_engine #(
        .NUM_CH(4), .MAX_LEN(3), .TICK_DIV(4),
        .ON_TICKS(1), .OFF_TICKS(1), .TIMEOUT_TICKS(5)
    ) dut_w (
        .clk(clk), .reset(reset), .btn(btn), .start(start_w),
        .led(led_w), .score(score_w), .phase(phase_w),
        .game_over(game_over_w), .win(win_w)
    );

    // Reference LFSR: x^16+x^14+x^13+x^11, seed 16'hACE1, shifts every clk.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    // Selects which instance the helper tasks observe.
    logic       sel;
    logic [3:0] o_led;
    logic [7:0] o_score;
    logic [2:0] o_phase;
    logic       o_game_over;
    logic       o_win;
    always_comb begin
        o_led       = sel ? led_w       : led;
        o_score     = sel ? score_w     : score;
        o_phase     = sel ? phase_w     : phase;
        o_game_over = sel ? game_over_w : game_over;
        o_win       = sel ? win_w       : win;
    end

    int         checks   = 0;
    int         failures = 0;
    logic [1:0] exp_seq [0:7];
    logic [1:0] wrong_ch;

    function automatic logic [3:0] oh(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Poll on falling edges until the observed phase matches; an expired
    // budget shows up as a failed comparison.
    task automatic wait_phase(input logic [2:0] target, input int budget, input string tag);
        int n = 0;
        while (o_phase !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 16'(o_phase), 16'(target));
    endtask

    // ADD of round n, then playback of n steps, ending on the first WAIT_IN
    // cycle. With ign set, stray presses are made during playback.
    task automatic show_round(input int n, input bit ign);
        wait_phase(3'd1, 40, "reach_add");
        exp_seq[n-1] = m_lfsr[1:0];
        chk("add_score", 16'(o_score), 16'(n - 1));
        for (int k = 0; k < n; k++) begin
            wait_phase(3'd2, 40, "reach_show_on");
            chk("show_on_led", 16'(o_led), 16'(oh(exp_seq[k])));
            if (ign && k == 1) begin
                btn = oh(exp_seq[k] + 2'd1);
                @(negedge clk);
                chk("ign_on_phase", 16'(o_phase), 16'd2);
                chk("ign_on_idx", 16'(dut.idx_reg), 16'd1);
                btn = 4'b0000;
            end
            wait_phase(3'd3, 40, "reach_show_off");
            chk("show_off_led", 16'(o_led), 16'd0);
            if (ign && k == 0) begin
                btn = 4'b0011;
                @(negedge clk);
                chk("ign_off_phase", 16'(o_phase), 16'd3);
                chk("ign_off_idx", 16'(dut.idx_reg), 16'd0);
                btn = 4'b0000;
            end
        end
        wait_phase(3'd4, 40, "reach_wait_in");
    endtask

    // Correct replay of all n entries.
    task automatic input_round(input int n, input int max_len);
        for (int k = 0; k < n; k++) begin
            btn = oh(exp_seq[k]);
            @(negedge clk);
            if (k < n - 1) begin
                chk("mid_phase", 16'(o_phase), 16'd4);
                chk("mid_led", 16'(o_led), 16'(oh(exp_seq[k])));
            end else begin
                chk("round_score", 16'(o_score), 16'(n));
                if (n == max_len) begin
                    chk("win_phase", 16'(o_phase), 16'd7);
                    chk("win_flag", 16'(o_win), 16'd1);
                    chk("win_led", 16'(o_led), 16'hF);
                end else begin
                    chk("gap_phase", 16'(o_phase), 16'd5);
                end
            end
            btn = 4'b0000;
            @(negedge clk);
        end
    endtask

    initial begin
        reset   = 1'b0;
        btn     = 4'b0000;
        start   = 1'b0;
        start_w = 1'b0;
        sel     = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst_led", 16'(led), 16'd0);
        chk("rst_score", 16'(score), 16'd0);
        chk("rst_phase", 16'(phase), 16'd0);
        chk("rst_game_over", 16'(game_over), 16'd0);
        chk("rst_win", 16'(win), 16'd0);
        chk("rst_lfsr", dut.lfsr_reg, 16'hACE1);
        chk("rst_w_phase", 16'(phase_w), 16'd0);
        chk("rst_w_led", 16'(led_w), 16'd0);

        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_phase", 16'(phase), 16'd0);

        // Game 1: three correct rounds, then a double press.
        start = 1'b1;
        @(negedge clk);
        chk("start_add", 16'(phase), 16'd1);
        start = 1'b0;
        show_round(1, 1'b0);
        input_round(1, 32);
        show_round(2, 1'b1);
        input_round(2, 32);
        show_round(3, 1'b0);
        input_round(3, 32);
        chk("score_three", 16'(score), 16'd3);
        show_round(4, 1'b0);
        btn = 4'b0101;
        @(negedge clk);
        chk("dbl_phase", 16'(phase), 16'd6);
        chk("dbl_game_over", 16'(game_over), 16'd1);
        chk("dbl_score", 16'(score), 16'd3);
        btn = 4'b0000;
        @(negedge clk);

        // Restart from LOSE.
        start = 1'b1;
        @(negedge clk);
        chk("restart_score", 16'(score), 16'd0);
        chk("restart_phase", 16'(phase), 16'd1);
        start = 1'b0;

        // Game 2: wrong channel in round 2.
        show_round(1, 1'b0);
        input_round(1, 32);
        show_round(2, 1'b0);
        wrong_ch = exp_seq[0] + 2'd1;
        btn = oh(wrong_ch);
        @(negedge clk);
        chk("wrong_phase", 16'(phase), 16'd6);
        chk("wrong_game_over", 16'(game_over), 16'd1);
        chk("wrong_score", 16'(score), 16'd1);
        btn = 4'b0000;
        @(negedge clk);

        // Game 3: idle behaviour in WAIT_IN.
        start = 1'b1;
        @(negedge clk);
        chk("start3_phase", 16'(phase), 16'd1);
        start = 1'b0;
        show_round(1, 1'b0);
        input_round(1, 32);
        show_round(2, 1'b0);
`ifdef SIMON_TIMEOUT_EN
        // WAIT_IN entered on a tick edge; first correct press lands before
        // the 4th tick and restarts the count, so LOSE comes 5 ticks later.
        repeat (13) @(negedge clk);
        btn = oh(exp_seq[0]);
        @(negedge clk);
        chk("to_press_phase", 16'(phase), 16'd4);
        btn = 4'b0000;
        repeat (11) @(negedge clk);
        chk("to_restart_phase", 16'(phase), 16'd4);
        repeat (6) @(negedge clk);
        chk("to_before_phase", 16'(phase), 16'd4);
        @(negedge clk);
        chk("to_lose_phase", 16'(phase), 16'd6);
        chk("to_lose_game_over", 16'(game_over), 16'd1);
`else
        repeat (400) @(negedge clk);
        chk("no_to_phase", 16'(phase), 16'd4);
        chk("no_to_game_over", 16'(game_over), 16'd0);
        wrong_ch = exp_seq[0] + 2'd2;
        btn = oh(wrong_ch);
        @(negedge clk);
        chk("no_to_lose", 16'(phase), 16'd6);
        btn = 4'b0000;
        @(negedge clk);
`endif

        // Win on the MAX_LEN=3 instance.
        sel = 1'b1;
        start_w = 1'b1;
        @(negedge clk);
        chk("w_start_phase", 16'(phase_w), 16'd1);
        start_w = 1'b0;
        show_round(1, 1'b0);
        input_round(1, 3);
        show_round(2, 1'b0);
        input_round(2, 3);
        show_round(3, 1'b0);
        input_round(3, 3);
        chk("w_score", 16'(score_w), 16'd3);
        chk("main_idle_lose", 16'(phase), 16'd6);

        // Asynchronous reset in the middle of SHOW_ON.
        sel = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("start4_phase", 16'(phase), 16'd1);
        start = 1'b0;
        wait_phase(3'd2, 40, "reach_show_on_rst");
        #2 reset = 1'b0;
        #1;
        chk("async_led", 16'(led), 16'd0);
        chk("async_phase", 16'(phase), 16'd0);
        chk("async_lfsr", dut.lfsr_reg, 16'hACE1);
        chk("async_w_win", 16'(win_w), 16'd0);
        chk("async_w_led", 16'(led_w), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
